// File: rtl/rf_mon_pkg.sv
// rtl/rf_mon_pkg.sv - shared types and constants for the register-file checkpoint monitor
package rf_mon_pkg;

  localparam int REG_AW = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam logic [REG_AW-1:0] X0_IDX = '0;

  // Table entries are stored at this width; a narrower XLEN is zero-extended into it.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FLAG,
    S_CHECK,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] flag;
    logic [REG_AW-1:0]   chk_reg;
    logic [MAX_XLEN-1:0] expected;
  } entry_t;

endpackage

// File: rtl/rf_checkpoint_monitor_if.sv
// rtl/rf_checkpoint_monitor_if.sv - register-file snoop and checkpoint-table programming bus
interface rf_checkpoint_monitor_if #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 8
);
  import rf_mon_pkg::*;

  logic                          rf_we;
  logic [REG_AW-1:0]             rf_waddr;
  logic [XLEN-1:0]               rf_wdata;
  logic                          cfg_we;
  logic [$clog2(NUM_CHECKS)-1:0] cfg_addr;
  logic [XLEN-1:0]               cfg_flag;
  logic [REG_AW-1:0]             cfg_reg;
  logic [XLEN-1:0]               cfg_expected;

  modport master (
    output rf_we, rf_waddr, rf_wdata,
    output cfg_we, cfg_addr, cfg_flag, cfg_reg, cfg_expected
  );

  modport slave (
    input rf_we, rf_waddr, rf_wdata,
    input cfg_we, cfg_addr, cfg_flag, cfg_reg, cfg_expected
  );

endinterface

// File: rtl/rf_mon_shadow.sv
// rtl/rf_mon_shadow.sv - shadow copy of the CPU register file with x0 guard and two read ports
module rf_mon_shadow
  import rf_mon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_flag_addr,
  input  logic [REG_AW-1:0] i_chk_addr,
  output logic [XLEN-1:0]   o_flag_data,
  output logic [XLEN-1:0]   o_chk_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  // Snoop the write port in every state; x0 is never written and keeps its reset zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != X0_IDX)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_flag_data = (i_flag_addr == X0_IDX) ? '0 : r_regs[i_flag_addr];
  assign o_chk_data  = (i_chk_addr  == X0_IDX) ? '0 : r_regs[i_chk_addr];

endmodule

// File: rtl/rf_checkpoint_monitor.sv
// rtl/rf_checkpoint_monitor.sv - checkpoint table sequencer; RF_MON_CYCLE_STAMP_EN enables the cycle stamp
module rf_checkpoint_monitor
  import rf_mon_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 8,
  parameter int FLAG_REG       = 20,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  rf_checkpoint_monitor_if.slave        bus,
  input  logic [$clog2(NUM_CHECKS):0]   num_checks,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [$clog2(NUM_CHECKS)-1:0] fail_index,
  output logic [XLEN-1:0]               fail_got,
  output logic [$clog2(NUM_CHECKS):0]   checks_passed,
  output logic [31:0]                   stamp
);

  localparam int IW = $clog2(NUM_CHECKS);
  localparam logic [IW:0] NUM_MAX = (IW+1)'(NUM_CHECKS);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic [REG_AW-1:0] FLAG_IDX = REG_AW'(FLAG_REG);

  state_e          r_state;
  state_e          w_state_next;
  entry_t          r_table [NUM_CHECKS];
  logic [IW-1:0]   r_idx;
  logic [IW:0]     r_num;
  logic [31:0]     r_cnt;
  logic            r_pass;
  logic            r_fail;
  logic            r_timeout;
  logic [IW-1:0]   r_fail_index;
  logic [XLEN-1:0] r_fail_got;
  logic [IW:0]     r_passed;

  entry_t          w_cur;
  logic [MAX_XLEN-1:0] w_nxt_flag;
  logic [XLEN-1:0] w_flag_data;
  logic [XLEN-1:0] w_chk_data;
  logic [31:0]     w_cnt_inc;
  logic [IW:0]     w_num_clamp;
  logic            w_flag_hit;
  logic            w_chk_ok;
  logic            w_is_last;
  logic            w_timeout_hit;
  logic            w_start_run;
  logic            w_do_timeout;
  logic            w_do_fail;
  logic            w_do_match;
  logic            w_do_pass;
  logic            w_do_adv;

  rf_mon_shadow #(
    .XLEN (XLEN)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .i_we        (bus.rf_we),
    .i_waddr     (bus.rf_waddr),
    .i_wdata     (bus.rf_wdata),
    .i_flag_addr (FLAG_IDX),
    .i_chk_addr  (w_cur.chk_reg),
    .o_flag_data (w_flag_data),
    .o_chk_data  (w_chk_data)
  );

  assign w_cur      = r_table[r_idx];
  assign w_nxt_flag = r_table[r_idx + 1'b1].flag;

  // Counter saturates at all-ones so a disabled timeout never wraps.
  assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_LIM);

  assign w_flag_hit = (MAX_XLEN'(w_flag_data) == w_cur.flag);
  assign w_chk_ok   = (MAX_XLEN'(w_chk_data) == w_cur.expected);
  assign w_is_last  = ({1'b0, r_idx} == (r_num - 1'b1));

  // Out-of-range entry counts are clamped so the run always terminates at a real entry.
  assign w_num_clamp = (num_checks == '0)     ? (IW+1)'(1) :
                       (num_checks > NUM_MAX) ? NUM_MAX    : num_checks;

  assign busy          = (r_state == S_WAIT_FLAG) || (r_state == S_CHECK);
  assign done          = (r_state == S_DONE);
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign timeout       = r_timeout;
  assign fail_index    = r_fail_index;
  assign fail_got      = r_fail_got;
  assign checks_passed = r_passed;

  // Table is only programmable while idle; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (r_state == S_IDLE)) begin
      r_table[bus.cfg_addr] <= '{flag:     MAX_XLEN'(bus.cfg_flag),
                                 chk_reg:  bus.cfg_reg,
                                 expected: MAX_XLEN'(bus.cfg_expected)};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle action strobes; timeout outranks any check outcome.
  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    w_do_timeout = 1'b0;
    w_do_fail    = 1'b0;
    w_do_match   = 1'b0;
    w_do_pass    = 1'b0;
    w_do_adv     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_run  = 1'b1;
          w_state_next = S_WAIT_FLAG;
        end
      end
      S_WAIT_FLAG: begin
        if (w_timeout_hit) begin
          w_do_timeout = 1'b1;
          w_state_next = S_DONE;
        end else if (w_flag_hit) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_timeout_hit) begin
          w_do_timeout = 1'b1;
          w_state_next = S_DONE;
        end else if (!w_chk_ok) begin
          w_do_fail    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_do_match = 1'b1;
          if (w_is_last) begin
            w_do_pass    = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_do_adv     = 1'b1;
            w_state_next = (w_nxt_flag == w_cur.flag) ? S_CHECK : S_WAIT_FLAG;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Run control: entry index, latched entry count and the run cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_num <= '0;
      r_cnt <= '0;
    end else if (w_start_run) begin
      r_idx <= '0;
      r_num <= w_num_clamp;
      r_cnt <= '0;
    end else begin
      if (busy) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_do_adv) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Result status; cleared on every start and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_index <= '0;
      r_fail_got   <= '0;
      r_passed     <= '0;
    end else if (w_start_run) begin
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_index <= '0;
      r_fail_got   <= '0;
      r_passed     <= '0;
    end else begin
      if (w_do_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_do_fail) begin
        r_fail       <= 1'b1;
        r_fail_index <= r_idx;
        r_fail_got   <= w_chk_data;
      end
      if (w_do_match && (r_passed != NUM_MAX)) begin
        r_passed <= r_passed + 1'b1;
      end
      if (w_do_pass) begin
        r_pass <= 1'b1;
      end
    end
  end

`ifdef RF_MON_CYCLE_STAMP_EN
  logic [31:0] r_stamp;
  logic        w_do_stamp;

  assign w_do_stamp = (r_state == S_CHECK) || w_do_timeout;

  // Record the run cycle count each time a check resolves or the timeout fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stamp <= '0;
    end else if (w_do_stamp) begin
      r_stamp <= w_cnt_inc;
    end
  end

  assign stamp = r_stamp;
`else
  assign stamp = '0;
`endif

endmodule

// File: tb/tb_rf_checkpoint_monitor.sv
// tb/tb_rf_checkpoint_monitor.sv - self-checking bench for rf_checkpoint_monitor
module tb_rf_checkpoint_monitor;

  localparam int XLEN = 32;
  localparam int NC   = 8;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IW:0]     num_checks = '0;
  logic            start = 1'b0;
  logic            busy, done, pass, fail, timeout;
  logic [IW-1:0]   fail_index;
  logic [XLEN-1:0] fail_got;
  logic [IW:0]     checks_passed;
  logic [31:0]     stamp;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_now  = 0;
  int t_start  = 0;

  rf_checkpoint_monitor_if #(.XLEN(XLEN), .NUM_CHECKS(NC)) bus ();

  rf_checkpoint_monitor #(
    .XLEN(XLEN), .NUM_CHECKS(NC), .FLAG_REG(20), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .num_checks(num_checks), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_index(fail_index), .fail_got(fail_got), .checks_passed(checks_passed),
    .stamp(stamp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] wr;
    logic [31:0] ex;
    logic        exp_pass;
    logic [31:0] exp_got;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.rf_we  = 1'b0;
    bus.cfg_we = 1'b0;
    start      = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cfg_entry(input int addr, input logic [31:0] flag, input logic [4:0] rg,
                           input logic [31:0] ex);
    bus.cfg_we       = 1'b1;
    bus.cfg_addr     = IW'(addr);
    bus.cfg_flag     = flag;
    bus.cfg_reg      = rg;
    bus.cfg_expected = ex;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    bus.rf_we    = 1'b1;
    bus.rf_waddr = a;
    bus.rf_wdata = d;
    tick();
    bus.rf_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_checks = (IW+1)'(n);
    start      = 1'b1;
    tick();
    start   = 1'b0;
    t_start = cyc_now;
  endtask

  task automatic wait_done(input string name, input int limit, output int elapsed);
    int c;
    c = 0;
    while (!done && c < limit) begin
      tick();
      c++;
    end
    elapsed = cyc_now - t_start;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic load_s1_table();
    cfg_entry(0, 32'd1, 5'd1, 32'd300);
    cfg_entry(1, 32'd2, 5'd1, 32'd500);
    cfg_entry(2, 32'd2, 5'd2, 32'd100);
  endtask

  task automatic run_s1(input string tag);
    int el;
    load_s1_table();
    start_run(3);
    rf_write(5'd1, 32'd300);
    rf_write(5'd20, 32'd1);
    repeat (4) tick();
    rf_write(5'd1, 32'd500);
    rf_write(5'd2, 32'd100);
    rf_write(5'd20, 32'd2);
    wait_done({tag, ".done"}, 100, el);
    chk({tag, ".pass"}, 64'(pass), 64'd1);
    chk({tag, ".fail"}, 64'(fail), 64'd0);
    chk({tag, ".timeout"}, 64'(timeout), 64'd0);
    chk({tag, ".checks_passed"}, 64'(checks_passed), 64'd3);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
`ifdef RF_MON_CYCLE_STAMP_EN
    chk({tag, ".stamp"}, 64'(stamp), 64'(el));
`else
    chk({tag, ".stamp"}, 64'(stamp), 64'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int el;
    int n, i, j, grp;
    logic [31:0] fl [6];
    logic [4:0]  rg [6];
    logic [31:0] ex [6];
    logic        bad [6];
    logic [31:0] m [32];
    logic [31:0] wv, got;
    logic        e_fail;
    int          e_cnt, e_idx;
    logic [31:0] e_got;

    vecs[0] = '{5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[1] = '{5'd5,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF};
    vecs[2] = '{5'd31, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001};
    vecs[3] = '{5'd31, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0};
    vecs[4] = '{5'd0,  32'h1234_5678, 32'h0000_0000, 1'b1, 32'h0};
    vecs[5] = '{5'd0,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0};
    vecs[6] = '{5'd1,  32'hA5A5_A5A5, 32'hA5A5_A5A4, 1'b0, 32'hA5A5_A5A5};
    vecs[7] = '{5'd19, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0};

    bus.rf_we = 1'b0; bus.rf_waddr = '0; bus.rf_wdata = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_flag = '0;
    bus.cfg_reg = '0; bus.cfg_expected = '0;

    // Reset state
    tick();
    chk("rst.outputs", 64'({busy, done, pass, fail, timeout, fail_index, checks_passed}), 64'd0);
    chk("rst.fail_got", 64'(fail_got), 64'd0);
    chk("rst.stamp", 64'(stamp), 64'd0);
    do_reset();

    // Scenario 1: two-flag, three-entry pass
    run_s1("s1");

    // start from DONE re-arms; cfg_we in DONE is ignored, so flag 1 never appears
    cfg_entry(0, 32'd2, 5'd1, 32'd500);
    start_run(3);
    chk("rearm.done_cleared", 64'(done), 64'd0);
    chk("rearm.busy", 64'(busy), 64'd1);
    chk("rearm.pass_cleared", 64'(pass), 64'd0);
    wait_done("rearm.done", 150, el);
    chk("rearm.timeout", 64'(timeout), 64'd1);
    chk("rearm.pass", 64'(pass), 64'd0);
    chk("rearm.elapsed", 64'(el), 64'd100);

    // Scenario 2: first check mismatches
    do_reset();
    load_s1_table();
    start_run(3);
    rf_write(5'd1, 32'd301);
    rf_write(5'd20, 32'd1);
    wait_done("s2.done", 50, el);
    chk("s2.fail", 64'(fail), 64'd1);
    chk("s2.fail_index", 64'(fail_index), 64'd0);
    chk("s2.fail_got", 64'(fail_got), 64'd301);
    chk("s2.pass", 64'(pass), 64'd0);
    chk("s2.checks_passed", 64'(checks_passed), 64'd0);

    // Scenario 3: flag never written
    do_reset();
    load_s1_table();
    start_run(3);
    wait_done("s3.done", 150, el);
    chk("s3.elapsed", 64'(el), 64'd100);
    chk("s3.flags", 64'({timeout, pass, fail}), 64'b100);
    chk("s3.checks_passed", 64'(checks_passed), 64'd0);
`ifdef RF_MON_CYCLE_STAMP_EN
    chk("s3.stamp", 64'(stamp), 64'd100);
`endif

    // Scenario 4: flag already matches, x0 write ignored
    do_reset();
    cfg_entry(0, 32'd1, 5'd0, 32'd0);
    rf_write(5'd0, 32'd55);
    rf_write(5'd20, 32'd1);
    start_run(1);
    wait_done("s4.done", 10, el);
    chk("s4.elapsed", 64'(el), 64'd2);
    chk("s4.pass", 64'(pass), 64'd1);
    chk("s4.checks_passed", 64'(checks_passed), 64'd1);

    // Scenario 5: reset mid-WAIT_FLAG, then clean rerun
    do_reset();
    load_s1_table();
    start_run(3);
    repeat (5) tick();
    chk("s5.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("s5.rst_outputs", 64'({busy, done, pass, fail, timeout, fail_index, checks_passed}), 64'd0);
    chk("s5.rst_got_stamp", 64'({fail_got, stamp}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_s1("s5.rerun");

    // Single-entry equality vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cfg_entry(0, 32'd9, vecs[v].rg, vecs[v].ex);
      rf_write(vecs[v].rg, vecs[v].wr);
      start_run(1);
      rf_write(5'd20, 32'd9);
      wait_done($sformatf("vec%0d.done", v), 20, el);
      chk($sformatf("vec%0d.pass", v), 64'(pass), 64'(vecs[v].exp_pass));
      chk($sformatf("vec%0d.fail", v), 64'(fail), 64'(!vecs[v].exp_pass));
      chk($sformatf("vec%0d.fail_got", v), 64'(fail_got), 64'(vecs[v].exp_got));
      chk($sformatf("vec%0d.checks_passed", v), 64'(checks_passed), 64'(vecs[v].exp_pass));
    end

    // Randomised runs against a register-array reference model
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < 6; k++) begin
        if (k == 0) fl[k] = $urandom_range(1, 50);
        else fl[k] = ($urandom_range(0, 1) == 1) ? fl[k-1] : fl[k-1] + $urandom_range(1, 50);
        rg[k]  = 5'($urandom_range(0, 19));
        ex[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
        bad[k] = ($urandom_range(0, 4) == 0);
      end
      for (int k = 0; k < 32; k++) m[k] = '0;
      e_fail = 1'b0; e_cnt = 0; e_idx = 0; e_got = '0;

      do_reset();
      for (int k = 0; k < n; k++) cfg_entry(k, fl[k], rg[k], ex[k]);
      start_run(n);

      i = 0;
      while (i < n && !e_fail) begin
        j = i;
        while (j < n && fl[j] == fl[i]) j++;
        grp = j - i;
        for (int k = i; k < j; k++) begin
          wv = bad[k] ? (ex[k] ^ ($urandom() | 32'd1)) : ex[k];
          if (rg[k] == 5'd0) wv = $urandom();
          rf_write(rg[k], wv);
          if (rg[k] != 5'd0) m[rg[k]] = wv;
        end
        rf_write(5'd20, fl[i]);
        repeat (grp + 3) tick();
        for (int k = i; k < j; k++) begin
          if (!e_fail) begin
            got = m[rg[k]];
            if (got == ex[k]) e_cnt++;
            else begin
              e_fail = 1'b1;
              e_idx  = k;
              e_got  = got;
            end
          end
        end
        i = j;
      end

      wait_done($sformatf("rnd%0d.done", r), 60, el);
      chk($sformatf("rnd%0d.pass", r), 64'(pass), 64'(!e_fail));
      chk($sformatf("rnd%0d.fail", r), 64'(fail), 64'(e_fail));
      chk($sformatf("rnd%0d.timeout", r), 64'(timeout), 64'd0);
      chk($sformatf("rnd%0d.fail_index", r), 64'(fail_index), 64'(e_idx));
      chk($sformatf("rnd%0d.fail_got", r), 64'(fail_got), 64'(e_got));
      chk($sformatf("rnd%0d.checks_passed", r), 64'(checks_passed), 64'(e_cnt));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
